// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: merges NUM_INPUTS valid/ready producers into one
// registered valid/ready output that carries the token and the winner's index.
module handshake_rr_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
    input  logic [NUM_INPUTS-1:0]            ins_valid,
    output logic [NUM_INPUTS-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]            outs,
    output logic [INDEX_WIDTH-1:0]           index,
    output logic                             outs_valid,
    input  logic                             outs_ready
);

    logic [INDEX_WIDTH-1:0] ptr;
    logic                   load;
    logic                   found_p0;
    logic [INDEX_WIDTH-1:0] grant_idx_p0;
    logic [DATA_WIDTH-1:0]  grant_data_p0;

    // Explicit wrap keeps non-power-of-2 channel counts correct.
    function automatic logic [INDEX_WIDTH-1:0] next_ptr(input logic [INDEX_WIDTH-1:0] g);
        if (g == INDEX_WIDTH'(NUM_INPUTS - 1))
            return '0;
        return g + 1'b1;
    endfunction

    assign load = !outs_valid || outs_ready;

    // Stage p0: rotating-priority search starting at ptr
    always_comb begin
        int j;
        found_p0      = 1'b0;
        grant_idx_p0  = '0;
        grant_data_p0 = '0;
        ins_ready     = '0;
        j             = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_INPUTS)
                j = j - NUM_INPUTS;
            if (!found_p0 && ins_valid[j]) begin
                found_p0      = 1'b1;
                grant_idx_p0  = INDEX_WIDTH'(j);
                grant_data_p0 = ins[j*DATA_WIDTH +: DATA_WIDTH];
                // ins_ready is held low during reset so no token is consumed then.
                if (load && !rst)
                    ins_ready[j] = 1'b1;
            end
        end
    end

    // Stage p1: one-entry output register and priority pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs       <= '0;
            index      <= '0;
            outs_valid <= 1'b0;
            ptr        <= '0;
        end else if (load) begin
            if (found_p0) begin
                outs       <= grant_data_p0;
                index      <= grant_idx_p0;
                outs_valid <= 1'b1;
                ptr        <= next_ptr(grant_idx_p0);
            end else begin
                outs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: a 4-input instance for the main
// sequence and a 3-input instance for the non-power-of-2 wrap.
module tb_handshake_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ins;
    logic [3:0]   ins_valid;
    logic [3:0]   ins_ready;
    logic [31:0]  outs;
    logic [1:0]   index;
    logic         outs_valid;
    logic         outs_ready;

    logic         rst3;
    logic [95:0]  ins3;
    logic [2:0]   ins_valid3;
    logic [2:0]   ins_ready3;
    logic [31:0]  outs3;
    logic [1:0]   index3;
    logic         outs_valid3;
    logic         outs_ready3;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .index(index), .outs_valid(outs_valid), .outs_ready(outs_ready)
    );

    handshake_rr_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) u_dut3 (
        .clk(clk), .rst(rst3), .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
        .outs(outs3), .index(index3), .outs_valid(outs_valid3), .outs_ready(outs_ready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] i);
        check({tag, "_valid"}, 32'(outs_valid), 32'(v));
        check({tag, "_outs"}, outs, d);
        check({tag, "_index"}, 32'(index), 32'(i));
    endtask

    initial begin
        rst        = 1'b1;
        rst3       = 1'b1;
        ins        = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        ins3       = {32'hB2, 32'hB1, 32'hB0};
        ins_valid  = '0;
        ins_valid3 = '0;
        outs_ready = 1'b0;
        outs_ready3 = 1'b0;

        // Reset held with random requests
        for (int c = 0; c < 3; c++) begin
            tick();
            ins_valid  = 4'($urandom);
            outs_ready = 1'($urandom);
            settle();
            check_out("reset", 1'b0, 32'h0, 2'd0);
            check("reset_ready", 32'(ins_ready), 32'h0);
        end

        // Full contention
        tick();
        rst        = 1'b0;
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        settle();
        check("fc_ready0", 32'(ins_ready), 32'b0001);
        check_out("fc_idle", 1'b0, 32'h0, 2'd0);
        tick(); settle();
        check_out("fc_0", 1'b1, 32'hA0, 2'd0);
        check("fc_ready1", 32'(ins_ready), 32'b0010);
        tick(); settle();
        check_out("fc_1", 1'b1, 32'hA1, 2'd1);
        check("fc_ready2", 32'(ins_ready), 32'b0100);
        tick(); settle();
        check_out("fc_2", 1'b1, 32'hA2, 2'd2);
        check("fc_ready3", 32'(ins_ready), 32'b1000);
        tick(); settle();
        check_out("fc_3", 1'b1, 32'hA3, 2'd3);
        check("fc_ready4", 32'(ins_ready), 32'b0001);
        tick(); settle();
        check_out("fc_4", 1'b1, 32'hA0, 2'd0);
        check("fc_ready5", 32'(ins_ready), 32'b0010);
        tick(); settle();
        check_out("fc_5", 1'b1, 32'hA1, 2'd1);
        check("fc_ready6", 32'(ins_ready), 32'b0100);

        // Backpressure: channel 2 token held, ptr = 3
        tick();
        outs_ready = 1'b0;
        ins_valid  = 4'b1011;
        settle();
        check_out("bp_load", 1'b1, 32'hA2, 2'd2);
        check("bp_ready_load", 32'(ins_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick(); settle();
            check_out("bp_hold", 1'b1, 32'hA2, 2'd2);
            check("bp_ready_hold", 32'(ins_ready), 32'h0);
        end
        outs_ready = 1'b1;
        settle();
        check("bp_release_ready", 32'(ins_ready), 32'b1000);
        tick(); settle();
        check_out("bp_next", 1'b1, 32'hA3, 2'd3);

        // Skip and wrap: first steer ptr to 3 via channel 2
        ins_valid = 4'b0100;
        settle();
        check("sw_pre_ready", 32'(ins_ready), 32'b0100);
        tick();
        ins_valid = 4'b0010;
        settle();
        check_out("sw_pre", 1'b1, 32'hA2, 2'd2);
        check("sw_skip_ready", 32'(ins_ready), 32'b0010);
        tick();
        ins_valid = 4'b0001;
        settle();
        check_out("sw_skip", 1'b1, 32'hA1, 2'd1);
        check("sw_wrap_ready", 32'(ins_ready), 32'b0001);
        tick();
        ins_valid = 4'b0010;
        settle();
        check_out("sw_wrap", 1'b1, 32'hA0, 2'd0);

        // Idle drain of a single channel-1 token
        check("id_ready", 32'(ins_ready), 32'b0010);
        tick();
        ins_valid = 4'b0000;
        settle();
        check_out("id_1", 1'b1, 32'hA1, 2'd1);
        check("id_ready_none", 32'(ins_ready), 32'h0);
        tick(); settle();
        check_out("id_drained", 1'b0, 32'hA1, 2'd1);
        tick();
        ins_valid = 4'b1111;
        settle();
        check_out("id_still", 1'b0, 32'hA1, 2'd1);
        check("id_ptr2_ready", 32'(ins_ready), 32'b0100);

        // Reset mid-operation with a held token
        tick();
        outs_ready = 1'b0;
        ins_valid  = 4'b0000;
        settle();
        check_out("rm_held", 1'b1, 32'hA2, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check_out("rm_async", 1'b0, 32'h0, 2'd0);
        check("rm_ready", 32'(ins_ready), 32'h0);
        #1;
        rst = 1'b0;
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        settle();
        check("rm_restart_ready", 32'(ins_ready), 32'b0001);
        tick(); settle();
        check_out("rm_first", 1'b1, 32'hA0, 2'd0);

        // Three-input variant: wrap 2 -> 0
        rst3        = 1'b0;
        ins_valid3  = 3'b111;
        outs_ready3 = 1'b1;
        settle();
        check("n3_ready0", 32'(ins_ready3), 32'b001);
        tick(); settle();
        check("n3_idx0", 32'(index3), 32'd0);
        check("n3_outs0", outs3, 32'hB0);
        check("n3_ready1", 32'(ins_ready3), 32'b010);
        tick(); settle();
        check("n3_idx1", 32'(index3), 32'd1);
        check("n3_ready2", 32'(ins_ready3), 32'b100);
        tick(); settle();
        check("n3_idx2", 32'(index3), 32'd2);
        check("n3_outs2", outs3, 32'hB2);
        check("n3_ready_wrap", 32'(ins_ready3), 32'b001);
        tick(); settle();
        check("n3_idx_wrap", 32'(index3), 32'd0);
        check("n3_outs_wrap", outs3, 32'hB0);
        check("n3_valid", 32'(outs_valid3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
